// File: rtl/spi_adxl362_responder.sv
// spi_adxl362_responder
// SPI mode-0 responder that mimics the ADXL362 register interface.
// Commands 0x0A (write) and 0x0B (read) are followed by an address byte and
// any number of data bytes, with the address auto-incrementing after each
// data byte. A 64-byte register file sits behind the interface. Registers
// 0x08..0x0A hold sensor values that the fabric loads with sample_valid.
// All SPI pins are oversampled in the clk domain, so clk must run at least
// 8x faster than sclk.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   sclk, cs_n    SPI clock and chip select (asynchronous inputs)
//   mosi, miso    SPI data in / data out
//   sample_valid  one-cycle pulse; loads x_data/y_data/z_data into 0x08..0x0A
//   busy          synchronized chip select is low
//   wr_strobe     one-cycle pulse per accepted SPI write (wr_addr/wr_data)
//   cmd_err       one-cycle pulse on an unknown command byte
//   xact_done     one-cycle pulse when chip select rises after a transaction
module spi_adxl362_responder #(
  parameter int         NUM_REGS      = 64,
  parameter logic [7:0] WRITABLE_BASE = 8'h1F,
  parameter logic [7:0] DEVID_AD      = 8'hAD,
  parameter logic [7:0] DEVID_MST     = 8'h1D,
  parameter logic [7:0] PARTID        = 8'hF2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic       sample_valid,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  input  logic [7:0] z_data,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_err,
  output logic       xact_done
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_READ   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  // Pin synchronizers. The third sclk/cs_n stage only serves edge detection.
  logic sclk_s1_reg, sclk_s2_reg, sclk_s3_reg;
  logic cs_n_s1_reg, cs_n_s2_reg, cs_n_s3_reg;
  logic mosi_s1_reg, mosi_s2_reg;
  logic [1:0] sync_fill_reg;
  logic cs_arm_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1_reg   <= 1'b0;
      sclk_s2_reg   <= 1'b0;
      sclk_s3_reg   <= 1'b0;
      cs_n_s1_reg   <= 1'b1;
      cs_n_s2_reg   <= 1'b1;
      cs_n_s3_reg   <= 1'b1;
      mosi_s1_reg   <= 1'b0;
      mosi_s2_reg   <= 1'b0;
      sync_fill_reg <= 2'd0;
      cs_arm_reg    <= 1'b0;
    end else begin
      sclk_s1_reg <= sclk;
      sclk_s2_reg <= sclk_s1_reg;
      sclk_s3_reg <= sclk_s2_reg;
      cs_n_s1_reg <= cs_n;
      cs_n_s2_reg <= cs_n_s1_reg;
      cs_n_s3_reg <= cs_n_s2_reg;
      mosi_s1_reg <= mosi;
      mosi_s2_reg <= mosi_s1_reg;
      if (sync_fill_reg != 2'd2) begin
        sync_fill_reg <= sync_fill_reg + 2'd1;
      end
      // The synchronizer reset value of cs_n is not a real observation. Only
      // once a genuine high level has propagated is a falling edge trusted,
      // so a reset in the middle of a transaction ignores the rest of it.
      if (sync_fill_reg == 2'd2 && cs_n_s2_reg) begin
        cs_arm_reg <= 1'b1;
      end
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_s2_reg & ~sclk_s3_reg;
  assign sclk_fall = ~sclk_s2_reg & sclk_s3_reg;
  assign cs_rise   = cs_n_s2_reg & ~cs_n_s3_reg;
  assign cs_fall   = ~cs_n_s2_reg & cs_n_s3_reg & cs_arm_reg;

  // Protocol state
  logic [2:0] state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_in_reg, shift_in_next;
  logic [7:0] shift_out_reg, shift_out_next;
  logic [7:0] addr_reg, addr_next;
  logic       wr_flag_reg, wr_flag_next;
  logic       miso_reg, miso_next;
  logic       wr_strobe_reg, wr_strobe_next;
  logic [7:0] wr_addr_reg, wr_addr_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic       cmd_err_reg, cmd_err_next;
  logic       xact_done_reg, xact_done_next;
  logic       reg_we;

  logic [7:0] byte_val;
  assign byte_val = {shift_in_reg, mosi_s2_reg};

  // Register file with a single read port. The read result is captured in
  // shift_out at byte boundaries, so sensor updates never tear a byte.
  logic [7:0] regs [NUM_REGS];
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  assign rd_addr = (state_reg == ST_ADDR) ? byte_val : addr_reg + 8'd1;
  assign rd_data = (32'(rd_addr) < NUM_REGS) ? regs[rd_addr[AW-1:0]] : 8'h00;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [7:0] INIT_VAL = (gi == 0) ? DEVID_AD  :
                                        (gi == 1) ? DEVID_MST :
                                        (gi == 2) ? PARTID    : 8'h00;
      localparam logic [7:0] ADDR_GI  = 8'(gi);
      logic [7:0] value_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          value_reg <= INIT_VAL;
        end else if (sample_valid && (gi >= 8) && (gi <= 10)) begin
          value_reg <= (gi == 8) ? x_data : (gi == 9) ? y_data : z_data;
        end else if (reg_we && (addr_reg == ADDR_GI)) begin
          value_reg <= byte_val;
        end
      end

      assign regs[gi] = value_reg;
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_in_next  = shift_in_reg;
    shift_out_next = shift_out_reg;
    addr_next      = addr_reg;
    wr_flag_next   = wr_flag_reg;
    miso_next      = miso_reg;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    cmd_err_next   = 1'b0;
    xact_done_next = 1'b0;
    reg_we         = 1'b0;

    if (cs_rise && state_reg != ST_IDLE) begin
      // Any partial byte is simply dropped.
      state_next     = ST_IDLE;
      xact_done_next = 1'b1;
      miso_next      = 1'b0;
    end else if (cs_fall && state_reg == ST_IDLE) begin
      state_next   = ST_CMD;
      bit_cnt_next = 3'd0;
      miso_next    = 1'b0;
    end else if (state_reg != ST_IDLE) begin
      if (sclk_rise) begin
        shift_in_next = byte_val[6:0];
        bit_cnt_next  = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          case (state_reg)
            ST_CMD: begin
              if (byte_val == 8'h0A) begin
                state_next   = ST_ADDR;
                wr_flag_next = 1'b1;
              end else if (byte_val == 8'h0B) begin
                state_next   = ST_ADDR;
                wr_flag_next = 1'b0;
              end else begin
                state_next   = ST_IGNORE;
                cmd_err_next = 1'b1;
              end
            end
            ST_ADDR: begin
              addr_next = byte_val;
              if (wr_flag_reg) begin
                state_next = ST_WRITE;
              end else begin
                state_next     = ST_READ;
                shift_out_next = rd_data;
              end
            end
            ST_WRITE: begin
              if (addr_reg >= WRITABLE_BASE && 32'(addr_reg) < NUM_REGS) begin
                reg_we         = 1'b1;
                wr_strobe_next = 1'b1;
                wr_addr_next   = addr_reg;
                wr_data_next   = byte_val;
              end
              addr_next = addr_reg + 8'd1;
            end
            ST_READ: begin
              addr_next      = addr_reg + 8'd1;
              shift_out_next = rd_data;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_reg == ST_READ) begin
        miso_next      = shift_out_reg[7];
        shift_out_next = {shift_out_reg[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_in_reg  <= 7'd0;
      shift_out_reg <= 8'h00;
      addr_reg      <= 8'h00;
      wr_flag_reg   <= 1'b0;
      miso_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= 8'h00;
      wr_data_reg   <= 8'h00;
      cmd_err_reg   <= 1'b0;
      xact_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_in_reg  <= shift_in_next;
      shift_out_reg <= shift_out_next;
      addr_reg      <= addr_next;
      wr_flag_reg   <= wr_flag_next;
      miso_reg      <= miso_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      cmd_err_reg   <= cmd_err_next;
      xact_done_reg <= xact_done_next;
    end
  end

  assign miso      = miso_reg;
  assign busy      = ~cs_n_s2_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign cmd_err   = cmd_err_reg;
  assign xact_done = xact_done_reg;

endmodule

// File: tb/tb_spi_adxl362_responder.sv
// tb_spi_adxl362_responder
// Directed bench for spi_adxl362_responder: drives SPI mode-0 transfers at
// clk/16, counts wr_strobe/cmd_err/xact_done pulses and compares read data
// and status outputs against hand-computed values.
module tb_spi_adxl362_responder;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       sample_valid;
  logic [7:0] x_data;
  logic [7:0] y_data;
  logic [7:0] z_data;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_err;
  logic       xact_done;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int n_err  = 0;
  int n_done = 0;

  spi_adxl362_responder dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .sample_valid (sample_valid),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .busy         (busy),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cmd_err      (cmd_err),
    .xact_done    (xact_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) n_wr <= n_wr + 1;
    if (cmd_err)   n_err <= n_err + 1;
    if (xact_done) n_done <= n_done + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shifts nbits of tx MSB first; rx collects miso sampled just before each
  // rising sclk. A sample_valid pulse (x=0x99) is issued after bit pulse_bit.
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          input int nbits, input int pulse_bit);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(8);
      rx[7-i] = miso;
      sclk = 1'b1;
      if (i == pulse_bit) begin
        wait_clk(2);
        x_data = 8'h99;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        wait_clk(5);
      end else begin
        wait_clk(8);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(12);
  endtask

  logic [7:0] rx;
  int snap_wr, snap_err, snap_done;
  logic miso_ok;

  initial begin
    rst = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    sample_valid = 1'b0;
    x_data = 8'h00;
    y_data = 8'h00;
    z_data = 8'h00;
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'h00);
    check("rst_wr_data", 32'(wr_data), 32'h00);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_xact_done", 32'(xact_done), 32'd0);
    rst = 1'b0;
    wait_clk(6);

    // 1: ID burst read
    snap_done = n_done;
    cs_begin();
    check("t1_busy", 32'(busy), 32'd1);
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t1_devid_ad", 32'(rx), 32'hAD);
    spi_byte(8'h00, rx, 8, -1);
    check("t1_devid_mst", 32'(rx), 32'h1D);
    spi_byte(8'h00, rx, 8, -1);
    check("t1_partid", 32'(rx), 32'hF2);
    cs_end();
    check("t1_xact_done", 32'(n_done - snap_done), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2: write 0x2D then read back
    snap_wr = n_wr;
    cs_begin();
    spi_byte(8'h0A, rx, 8, -1);
    spi_byte(8'h2D, rx, 8, -1);
    spi_byte(8'h02, rx, 8, -1);
    cs_end();
    check("t2_wr_count", 32'(n_wr - snap_wr), 32'd1);
    check("t2_wr_addr", 32'(wr_addr), 32'h2D);
    check("t2_wr_data", 32'(wr_data), 32'h02);
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h2D, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t2_readback", 32'(rx), 32'h02);
    cs_end();

    // 3: sensor load and tear-free snapshot
    x_data = 8'h12;
    y_data = 8'h34;
    z_data = 8'h56;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    wait_clk(2);
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h08, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t3_x", 32'(rx), 32'h12);
    spi_byte(8'h00, rx, 8, -1);
    check("t3_y", 32'(rx), 32'h34);
    spi_byte(8'h00, rx, 8, -1);
    check("t3_z", 32'(rx), 32'h56);
    cs_end();
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h08, rx, 8, -1);
    spi_byte(8'h00, rx, 8, 3);
    check("t3_no_tear", 32'(rx), 32'h12);
    cs_end();
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h08, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t3_x_updated", 32'(rx), 32'h99);
    cs_end();

    // 4: invalid command
    snap_wr = n_wr;
    snap_err = n_err;
    snap_done = n_done;
    cs_begin();
    spi_byte(8'h55, rx, 8, -1);
    miso_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_clk(1);
      if (miso !== 1'b0) miso_ok = 1'b0;
    end
    check("t4_miso_quiet", 32'(miso_ok), 32'd1);
    spi_byte(8'hFF, rx, 8, -1);
    check("t4_ignored_rx", 32'(rx), 32'h00);
    cs_end();
    check("t4_cmd_err", 32'(n_err - snap_err), 32'd1);
    check("t4_no_write", 32'(n_wr - snap_wr), 32'd0);
    check("t4_xact_done", 32'(n_done - snap_done), 32'd1);
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h02, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t4_read_after", 32'(rx), 32'hF2);
    cs_end();

    // 5: read-only and out-of-range writes
    snap_wr = n_wr;
    cs_begin();
    spi_byte(8'h0A, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    spi_byte(8'hFF, rx, 8, -1);
    cs_end();
    check("t5_ro_no_write", 32'(n_wr - snap_wr), 32'd0);
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t5_ro_readback", 32'(rx), 32'hAD);
    cs_end();
    snap_wr = n_wr;
    cs_begin();
    spi_byte(8'h0A, rx, 8, -1);
    spi_byte(8'h3F, rx, 8, -1);
    spi_byte(8'h11, rx, 8, -1);
    spi_byte(8'h22, rx, 8, -1);
    cs_end();
    check("t5_edge_wr_count", 32'(n_wr - snap_wr), 32'd1);
    check("t5_edge_wr_addr", 32'(wr_addr), 32'h3F);
    check("t5_edge_wr_data", 32'(wr_data), 32'h11);
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h3F, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t5_read_3f", 32'(rx), 32'h11);
    spi_byte(8'h00, rx, 8, -1);
    check("t5_read_40", 32'(rx), 32'h00);
    cs_end();

    // 6a: chip select raised mid data byte
    snap_wr = n_wr;
    snap_done = n_done;
    cs_begin();
    spi_byte(8'h0A, rx, 8, -1);
    spi_byte(8'h30, rx, 8, -1);
    spi_byte(8'hAB, rx, 4, -1);
    cs_end();
    check("t6_partial_no_write", 32'(n_wr - snap_wr), 32'd0);
    check("t6_partial_done", 32'(n_done - snap_done), 32'd1);
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h30, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t6_partial_readback", 32'(rx), 32'h00);
    cs_end();

    // 6b: reset in the middle of a read of 0x00 (0xAD, MSB = 1)
    snap_done = n_done;
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    wait_clk(8);
    check("t6_pre_rst_miso", 32'(miso), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_miso", 32'(miso), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_wr_addr", 32'(wr_addr), 32'h00);
    wait_clk(2);
    rst = 1'b0;
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t6_ignored_after_rst", 32'(rx), 32'h00);
    cs_end();
    check("t6_no_done_after_rst", 32'(n_done - snap_done), 32'd0);
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h2D, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t6_2d_reset", 32'(rx), 32'h00);
    cs_end();
    cs_begin();
    spi_byte(8'h0B, rx, 8, -1);
    spi_byte(8'h08, rx, 8, -1);
    spi_byte(8'h00, rx, 8, -1);
    check("t6_08_reset", 32'(rx), 32'h00);
    cs_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
